mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 40 ++++
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the byte-serial memory arbiter: truth constants, width
// codes, FSM encodings, grant/pointer types and the byte-count lookup.
package mem_arbiter_pkg;

    localparam logic True_v  = 1'b1;
    localparam logic False_v = 1'b0;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic [2:0] IF_BYTES = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IF   = 2'b01,
        GNT_MEM  = 2'b10
    } grant_t;

    typedef enum logic {
        LAST_IF  = 1'b0,
        LAST_MEM = 1'b1
    } last_t;

    // Codes 10 and 11 both mean a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: byte_count = 3'd1;
            WIDTH_HALF: byte_count = 3'd2;
            default:    byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the IF and MEM requesters.
// reqs[1] is MEM, reqs[0] is IF; pointer names the requester served last.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] reqs,
    input  last_t      pointer,
    output grant_t     grant
);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        grant = GNT_NONE;
        case (reqs)
            2'b01:   grant = GNT_IF;
            2'b10:   grant = GNT_MEM;
            2'b11:   grant = (pointer == LAST_MEM) ? GNT_IF : GNT_MEM;
            default: grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto a byte-wide synchronous RAM.
// Define MEM_ARB_RR_EN for round-robin on contention; default is MEM priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    input  logic [7:0]  ram_din
);

    state_t      state, state_nx;
    grant_t      gnt, pick;
    last_t       pointer;
    logic [2:0]  cnt, nbytes;
    logic [31:0] base, wdata, rbuf, rbuf_nx;
    logic        we;
    logic [1:0]  rd_sel, wr_sel;

    mem_arb_pick u_pick (
        .reqs    ({mem_req, if_req}),
        .pointer (pointer),
        .grant   (pick)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pointer <= LAST_MEM;
        else if (rdy && state == ST_IDLE && pick != GNT_NONE)
            pointer <= (pick == GNT_MEM) ? LAST_MEM : LAST_IF;
    end
`else
    // A constant "IF last" makes the picker favour MEM on contention.
    assign pointer = LAST_IF;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else if (rdy)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (pick != GNT_NONE) state_nx = ST_BUSY;
            ST_BUSY: if (we ? (cnt == nbytes - 3'd1) : (cnt == nbytes)) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Byte cnt-1 arrives now, one cycle after its address was presented.
    assign rd_sel = cnt[1:0] - 2'd1;
    assign wr_sel = cnt[1:0];

    always_comb begin
        rbuf_nx = rbuf;
        if (cnt != 3'd0)
            rbuf_nx[{rd_sel, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= GNT_NONE;
            cnt       <= 3'd0;
            nbytes    <= 3'd0;
            base      <= 32'd0;
            wdata     <= 32'd0;
            we        <= False_v;
            rbuf      <= 32'd0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (pick != GNT_NONE) begin
                        gnt  <= pick;
                        cnt  <= 3'd0;
                        rbuf <= 32'd0;
                        if (pick == GNT_MEM) begin
                            base   <= mem_addr;
                            wdata  <= mem_wdata;
                            we     <= mem_we;
                            nbytes <= byte_count(mem_width);
                        end else begin
                            base   <= if_addr;
                            wdata  <= 32'd0;
                            we     <= False_v;
                            nbytes <= IF_BYTES;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 3'd1;
                    if (!we) begin
                        rbuf <= rbuf_nx;
                        // Results are published only on completion so they stay stable.
                        if (cnt == nbytes) begin
                            if (gnt == GNT_IF)
                                if_data <= rbuf_nx;
                            else
                                mem_rdata <= rbuf_nx;
                        end
                    end
                end
                ST_DONE: begin
                    gnt <= GNT_NONE;
                    cnt <= 3'd0;
                end
                default: begin
                    gnt <= GNT_NONE;
                    cnt <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        if_done  = (state == ST_DONE) && (gnt == GNT_IF);
        mem_done = (state == ST_DONE) && (gnt == GNT_MEM);
        ram_a    = 32'd0;
        ram_dout = 8'd0;
        ram_wr   = False_v;
        if (state == ST_BUSY && cnt < nbytes) begin
            ram_a = base + {29'd0, cnt};
            if (we) begin
                ram_dout = wdata[{wr_sel, 3'b000} +: 8];
                ram_wr   = rdy;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a byte-wide synchronous RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    logic [7:0]  ram_mem [256];
    int          wr_count;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_width (mem_width),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_a     (ram_a),
        .ram_dout  (ram_dout),
        .ram_wr    (ram_wr),
        .ram_din   (ram_din)
    );

    // Synchronous RAM that stalls together with rdy; only the low address byte decodes.
    always @(posedge clk) begin
        if (rdy) begin
            ram_din <= ram_mem[ram_a[7:0]];
            if (ram_wr) begin
                ram_mem[ram_a[7:0]] <= ram_dout;
                wr_count <= wr_count + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_a [1:8];
        int          wr0;
        int          pulses;

        for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
        wr_count  = 0;
        ram_din   = 8'h00;
        rst       = 1'b0;
        rdy       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_width = 2'b00;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;

        #2;
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
        #10 rst = 1'b1;

        // IF word read; request dropped and address changed right after grant.
        ram_mem[8'h00] = 8'h11; ram_mem[8'h01] = 8'h22;
        ram_mem[8'h02] = 8'h33; ram_mem[8'h03] = 8'h44;
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin if_req = 1'b0; if_addr = 32'hDEAD_BEEF; end
            #1;
            check("rd_ram_a", ram_a, (c <= 4) ? 32'h100 + 32'(c) - 32'd1 : 32'd0);
            check("rd_if_done", {31'd0, if_done}, {31'd0, c == 6});
            check("rd_ram_wr", {31'd0, ram_wr}, 32'd0);
        end
        check("rd_if_data", if_data, 32'h4433_2211);

        // MEM byte write.
        wr0 = wr_count;
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b00;
        mem_addr = 32'h20; mem_wdata = 32'hAABB_CCDD;
        tick();
        mem_req = 1'b0; #1;
        check("bw_ram_wr", {31'd0, ram_wr}, 32'd1);
        check("bw_ram_a", ram_a, 32'h20);
        check("bw_ram_dout", {24'd0, ram_dout}, 32'hDD);
        tick(); #1;
        check("bw_mem_done", {31'd0, mem_done}, 32'd1);
        check("bw_ram_wr_off", {31'd0, ram_wr}, 32'd0);
        tick(); #1;
        check("bw_done_once", {31'd0, mem_done}, 32'd0);
        check("bw_wr_count", 32'(wr_count - wr0), 32'd1);
        check("bw_ram_byte", {24'd0, ram_mem[8'h20]}, 32'hDD);

        ram_mem[8'h00] = 8'h01; ram_mem[8'h01] = 8'h02;
        ram_mem[8'h02] = 8'h03; ram_mem[8'h03] = 8'h04;
        ram_mem[8'h40] = 8'h5A; ram_mem[8'h41] = 8'hA5;

`ifndef MEM_ARB_RR_EN
        // Contention: MEM half read wins, IF is granted from the next IDLE.
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b01; mem_addr = 32'h40;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) mem_req = 1'b0;
            if (c == 6) if_req = 1'b0;
            #1;
            if (c == 1) check("arb_first_mem", ram_a, 32'h40);
            if (c == 6) check("arb_then_if", ram_a, 32'h100);
            if (c == 8) check("arb_if_data_hold", if_data, 32'h4433_2211);
            check("arb_mem_done", {31'd0, mem_done}, {31'd0, c == 4});
            check("arb_if_done", {31'd0, if_done}, {31'd0, c == 11});
        end
        check("arb_mem_rdata", mem_rdata, 32'h0000_A55A);
        check("arb_if_data", if_data, 32'h0403_0201);
`endif

        // Word read across the top of the address space.
        ram_mem[8'hFE] = 8'hEE; ram_mem[8'hFF] = 8'hFF;
        tick();
        if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
        exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) if_req = 1'b0;
            #1;
            check("wrap_ram_a", ram_a, exp_a[c]);
        end
        check("wrap_if_done", {31'd0, if_done}, 32'd1);
        check("wrap_if_data", if_data, 32'h0201_FFEE);

        // Word write stalled by rdy for three cycles at cnt=2.
        wr0 = wr_count;
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10;
        mem_addr = 32'h60; mem_wdata = 32'h8765_4321;
        exp_a = '{32'h60, 32'h61, 32'h62, 32'h62, 32'h62, 32'h62, 32'h63, 32'h0};
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) mem_req = 1'b0;
            if (c == 3) rdy = 1'b0;
            if (c == 6) rdy = 1'b1;
            #1;
            check("stall_ram_a", ram_a, exp_a[c]);
            check("stall_ram_wr", {31'd0, ram_wr}, {31'd0, c == 1 || c == 2 || c == 6 || c == 7});
            check("stall_mem_done", {31'd0, mem_done}, {31'd0, c == 8});
        end
        check("stall_wr_count", 32'(wr_count - wr0), 32'd4);
        check("stall_ram_word", {ram_mem[8'h63], ram_mem[8'h62], ram_mem[8'h61], ram_mem[8'h60]},
              32'h8765_4321);

        // Reset pulsed in the middle of a word read.
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        if_req = 1'b0;
        tick();
        tick();
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ram_a", ram_a, 32'd0);
        check("mid_rst_if_data", if_data, 32'd0);
        check("mid_rst_mem_rdata", mem_rdata, 32'd0);
        #1 rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); #1;
            if (if_done || mem_done) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h41;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) mem_req = 1'b0;
            #1;
        end
        check("after_rst_done", {31'd0, mem_done}, 32'd1);
        check("after_rst_rdata", mem_rdata, 32'h0000_00A5);

`ifdef MEM_ARB_RR_EN
        begin
            logic seq [8];
            int   n;
            n = 0;
            tick();
            if_req = 1'b1; if_addr = 32'h100;
            mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h40;
            for (int c = 0; c < 60 && n < 8; c++) begin
                tick(); #1;
                if (if_done || mem_done) begin
                    seq[n] = mem_done;
                    n++;
                end
            end
            if_req = 1'b0; mem_req = 1'b0;
            check("rr_grants_seen", {31'd0, n >= 4}, 32'd1);
            for (int i = 1; i < n; i++)
                check("rr_alternate", {31'd0, seq[i]}, {31'd0, ~seq[i-1]});
        end
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
